regfile_scoreboard: RTL and testbench
=====================================

Name: regfile_scoreboard

Overview:
- Parametrised busy-register scoreboard for the register file.
- Tracks which architectural registers have an outstanding write.
- Stalls issue on RAW or WAW hazards.
- Drives registered one-hot write enables to the register file from the writeback address. This is the decoded-enable role, now with state.

Parameters:
- ADDR_W, 5, register address width.
- NUM_REGS, 32, number of registers; must equal 2**ADDR_W.
- ZERO_REG, 1, when 1 register 0 is never marked busy and never write-enabled.

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- issue_valid  in  1  instruction presented for issue.
- issue_rd  in  ADDR_W  destination register of the issuing instruction.
- issue_rs1  in  ADDR_W  source register 1.
- issue_rs2  in  ADDR_W  source register 2.
- issue_uses_rd  in  1  instruction writes issue_rd.
- stall  out  1  combinational; issue blocked this cycle.
- wb_valid  in  1  writeback of a result this cycle.
- wb_rd  in  ADDR_W  writeback destination.
- wr_en  out  NUM_REGS  registered one-hot register-file write enables.
- busy_vec  out  NUM_REGS  registered busy bits.
- busy_count  out  ADDR_W+1  registered count of busy registers.
- err  out  1  sticky; writeback hit a non-busy register.

Behaviour:
- Reset (async, immediate): busy_vec=0, busy_count=0, wr_en=0, err=0.
- Hazard check (combinational):
  - rs1_hit = busy[issue_rs1].
  - rs2_hit = busy[issue_rs2].
  - rd_hit = issue_uses_rd & busy[issue_rd].
  - stall = issue_valid & (rs1_hit | rs2_hit | rd_hit).
- Accept: accept = issue_valid & ~stall.
- Busy set: if accept & issue_uses_rd, busy[issue_rd] is set at the next edge. Skipped when ZERO_REG=1 and issue_rd=0.
- Busy clear: if wb_valid, busy[wb_rd] is cleared at the next edge.
- Write enable: wr_en is the one-hot decode of wb_rd gated by wb_valid, registered. Latency 1 cycle; high for exactly one cycle per writeback.
  - Forced to 0 for wb_rd=0 when ZERO_REG=1.
  - Otherwise wr_en=0.
- Simultaneous set and clear on the same register: set wins and the bit stays busy (new producer outstanding). wr_en for that register still pulses.
- Writeback to a non-busy register: err set at the next edge, held until reset. Bit stays clear; wr_en still pulses.
- Writeback to register 0 with ZERO_REG=1: ignored, err not set.
- busy_count tracks popcount of busy_vec. Per edge it changes by +1, -1 or 0 from the effective set/clear; it must equal popcount(busy_vec) every cycle.
- Reset asserted mid-operation: all pending state is discarded immediately. The first edge after deassertion behaves as from an empty scoreboard.

Optional Feature:
- Macro: SB_BYPASS_EN.
- Defined: the hazard check uses busy_eff = busy & ~(wb_valid ? onehot(wb_rd) : 0). A register being written back this cycle does not stall a dependent issue.
- Undefined: the hazard check uses registered busy only, and a dependent issue stalls one extra cycle.
- Set/clear priority is identical either way.

Decomposition:
- Shared package regfile_pkg holds:
  - REG_ADDR_W=5 and NUM_REGS=32 constants.
  - typedef reg_addr_t (ADDR_W bits).
  - typedef reg_mask_t (NUM_REGS bits).
- One sub-module: reg_onehot_decoder. Parametrised ADDR_W-to-2**ADDR_W one-hot decoder with enable, combinational. Instantiated three times: issue set, wb clear, wr_en source.

Test Plan:
- Reset then issue rd=5 (rs1=1, rs2=2, uses_rd=1) -> stall=0; next cycle busy_vec=0x0000_0020, busy_count=1.
- With r5 busy, issue rs1=5 -> stall=1, busy unchanged. With wb_rd=5 in that same cycle:
  - SB_BYPASS_EN defined -> stall=0.
  - SB_BYPASS_EN undefined -> stall=1.
- wb_valid wb_rd=7 -> next cycle wr_en=0x0000_0080 for one cycle; then wr_en=0.
- Same cycle: accepted issue rd=9 and wb_rd=9 with r9 busy -> busy[9]=1, busy_count unchanged, wr_en[9] pulses.
- With r3 not busy, wb_rd=3 -> err=1 and stays 1. Issue rd=0 and wb_rd=0 (ZERO_REG=1) -> busy_vec[0]=0, wr_en=0, err not set.
- Fill r1..r31 busy, then assert reset mid-cycle -> busy_vec=0, busy_count=0, err=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared constants and types for the register-file busy scoreboard.
package regfile_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int NUM_REGS   = 32;

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;
    typedef logic [NUM_REGS-1:0]   reg_mask_t;

endpackage

// File: rtl/reg_onehot_decoder.sv
// Combinational ADDR_W-to-2**ADDR_W one-hot decoder with enable.
module reg_onehot_decoder
    import regfile_pkg::*;
#(
    parameter int ADDR_W = REG_ADDR_W
) (
    input  logic                   i_en,
    input  logic [ADDR_W-1:0]      i_addr,
    output logic [(2**ADDR_W)-1:0] o_onehot
);

    // Decode the address into a single set bit when enabled.
    always_comb begin
        o_onehot = {(2**ADDR_W){1'b0}};
        if (i_en) begin
            o_onehot[i_addr] = 1'b1;
        end else begin
            o_onehot = {(2**ADDR_W){1'b0}};
        end
    end

endmodule

// File: rtl/regfile_scoreboard.sv
// Busy-register scoreboard: RAW/WAW issue stall, registered one-hot write enables.
// Optional macro SB_BYPASS_EN lets a same-cycle writeback release a dependent issue.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int ADDR_W   = REG_ADDR_W,
    parameter int NUM_REGS = 2**ADDR_W,
    parameter int ZERO_REG = 1
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                issue_valid,
    input  logic [ADDR_W-1:0]   issue_rd,
    input  logic [ADDR_W-1:0]   issue_rs1,
    input  logic [ADDR_W-1:0]   issue_rs2,
    input  logic                issue_uses_rd,
    output logic                stall,
    input  logic                wb_valid,
    input  logic [ADDR_W-1:0]   wb_rd,
    output logic [NUM_REGS-1:0] wr_en,
    output logic [NUM_REGS-1:0] busy_vec,
    output logic [ADDR_W:0]     busy_count,
    output logic                err
);

    logic [NUM_REGS-1:0] r_busy;
    logic [NUM_REGS-1:0] r_wr_en;
    logic [ADDR_W:0]     r_count;
    logic                r_err;

    logic                w_rd_is_zero;
    logic                w_wb_is_zero;
    logic                w_accept;
    logic                w_set_en;
    logic                w_clr_en;
    logic [NUM_REGS-1:0] w_set_oh;
    logic [NUM_REGS-1:0] w_clr_oh;
    logic [NUM_REGS-1:0] w_wr_oh;
    logic [NUM_REGS-1:0] w_busy_chk;
    logic                w_inc;
    logic                w_dec;
    logic                w_wb_err;

    assign w_rd_is_zero = (ZERO_REG != 0) && (issue_rd == {ADDR_W{1'b0}});
    assign w_wb_is_zero = (ZERO_REG != 0) && (wb_rd == {ADDR_W{1'b0}});

`ifdef SB_BYPASS_EN
    // A register retiring this cycle no longer blocks its consumers.
    assign w_busy_chk = r_busy & ~w_clr_oh;
`else
    assign w_busy_chk = r_busy;
`endif

    assign stall    = issue_valid & (w_busy_chk[issue_rs1] | w_busy_chk[issue_rs2] |
                                     (issue_uses_rd & w_busy_chk[issue_rd]));
    assign w_accept = issue_valid & ~stall;
    assign w_set_en = w_accept & issue_uses_rd & ~w_rd_is_zero;
    assign w_clr_en = wb_valid & ~w_wb_is_zero;

    reg_onehot_decoder #(.ADDR_W(ADDR_W)) u_dec_set (
        .i_en     (w_set_en),
        .i_addr   (issue_rd),
        .o_onehot (w_set_oh)
    );

    reg_onehot_decoder #(.ADDR_W(ADDR_W)) u_dec_clr (
        .i_en     (w_clr_en),
        .i_addr   (wb_rd),
        .o_onehot (w_clr_oh)
    );

    reg_onehot_decoder #(.ADDR_W(ADDR_W)) u_dec_wr (
        .i_en     (w_clr_en),
        .i_addr   (wb_rd),
        .o_onehot (w_wr_oh)
    );

    // Set and clear are each one-hot, so the count moves by at most one either way.
    assign w_inc    = |(w_set_oh & ~r_busy);
    assign w_dec    = |(w_clr_oh & r_busy & ~w_set_oh);
    assign w_wb_err = |(w_clr_oh & ~r_busy);

    // Scoreboard state; set beats clear when both hit the same register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_busy  <= {NUM_REGS{1'b0}};
            r_wr_en <= {NUM_REGS{1'b0}};
            r_count <= {(ADDR_W+1){1'b0}};
            r_err   <= 1'b0;
        end else begin
            r_busy  <= (r_busy & ~w_clr_oh) | w_set_oh;
            r_wr_en <= w_wr_oh;
            r_count <= r_count + {{ADDR_W{1'b0}}, w_inc} - {{ADDR_W{1'b0}}, w_dec};
            r_err   <= r_err | w_wb_err;
        end
    end

    assign busy_vec   = r_busy;
    assign wr_en      = r_wr_en;
    assign busy_count = r_count;
    assign err        = r_err;

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Scoreboard-style bench: directed stimulus queues expectations, a monitor checks them.
module tb_regfile_scoreboard;
    import regfile_pkg::*;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        issue_valid = 1'b0;
    reg_addr_t   issue_rd = '0;
    reg_addr_t   issue_rs1 = '0;
    reg_addr_t   issue_rs2 = '0;
    logic        issue_uses_rd = 1'b0;
    logic        stall;
    logic        wb_valid = 1'b0;
    reg_addr_t   wb_rd = '0;
    reg_mask_t   wr_en;
    reg_mask_t   busy_vec;
    logic [5:0]  busy_count;
    logic        err;

    regfile_scoreboard dut (
        .clock         (clock),
        .reset         (reset),
        .issue_valid   (issue_valid),
        .issue_rd      (issue_rd),
        .issue_rs1     (issue_rs1),
        .issue_rs2     (issue_rs2),
        .issue_uses_rd (issue_uses_rd),
        .stall         (stall),
        .wb_valid      (wb_valid),
        .wb_rd         (wb_rd),
        .wr_en         (wr_en),
        .busy_vec      (busy_vec),
        .busy_count    (busy_count),
        .err           (err)
    );

    always #5 clock = ~clock;

    localparam int K_STALL = 0;
    localparam int K_BUSY  = 1;
    localparam int K_COUNT = 2;
    localparam int K_WREN  = 3;
    localparam int K_ERR   = 4;

    typedef struct {
        int          cyc;
        int          kind;
        logic [31:0] val;
        string       name;
    } chk_t;

    chk_t q[$];
    int   cyc = 0;
    int   n_checks = 0;
    int   n_errors = 0;
    event chk_ev;

    always @(posedge clock) cyc = cyc + 1;

    task automatic expect_at(input int dc, input int kind, input logic [31:0] v, input string nm);
        chk_t c;
        c.cyc  = (dc < 0) ? -1 : cyc + dc;
        c.kind = kind;
        c.val  = v;
        c.name = nm;
        q.push_back(c);
    endtask

    task automatic drive(input logic iv, input reg_addr_t rd, input reg_addr_t rs1,
                         input reg_addr_t rs2, input logic urd, input logic wv, input reg_addr_t wrd);
        @(posedge clock);
        #1;
        issue_valid   = iv;
        issue_rd      = rd;
        issue_rs1     = rs1;
        issue_rs2     = rs2;
        issue_uses_rd = urd;
        wb_valid      = wv;
        wb_rd         = wrd;
    endtask

    task automatic idle();
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0);
    endtask

    // Monitor: compare every expectation due at this sample point.
    initial begin
        logic [31:0] act;
        chk_t        c;
        forever begin
            @(negedge clock or chk_ev);
            while (q.size() > 0 && (q[0].cyc == -1 || q[0].cyc <= cyc)) begin
                c = q.pop_front();
                case (c.kind)
                    K_STALL: act = {31'd0, stall};
                    K_BUSY:  act = busy_vec;
                    K_COUNT: act = {26'd0, busy_count};
                    K_WREN:  act = wr_en;
                    K_ERR:   act = {31'd0, err};
                    default: act = 32'hDEAD_BEEF;
                endcase
                n_checks++;
                if (c.cyc != -1 && c.cyc < cyc) begin
                    n_errors++;
                    $display("FAIL %s: expectation not sampled in its cycle (due %0d, now %0d)",
                             c.name, c.cyc, cyc);
                end else if (act !== c.val) begin
                    n_errors++;
                    $display("FAIL %s: got 0x%08h expected 0x%08h", c.name, act, c.val);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
        expect_at(0, K_BUSY,  32'h0, "rst_busy");
        expect_at(0, K_COUNT, 32'd0, "rst_count");
        expect_at(0, K_WREN,  32'h0, "rst_wren");
        expect_at(0, K_ERR,   32'd0, "rst_err");

        // r5 becomes busy
        drive(1'b1, 5'd5, 5'd1, 5'd2, 1'b1, 1'b0, 5'd0);
        expect_at(0, K_STALL, 32'd0, "issue_r5_stall");
        expect_at(1, K_BUSY,  32'h0000_0020, "issue_r5_busy");
        expect_at(1, K_COUNT, 32'd1, "issue_r5_count");

        // RAW on r5 stalls
        drive(1'b1, 5'd10, 5'd5, 5'd0, 1'b1, 1'b0, 5'd0);
        expect_at(0, K_STALL, 32'd1, "raw_stall");
        expect_at(1, K_BUSY,  32'h0000_0020, "raw_busy_hold");
        expect_at(1, K_COUNT, 32'd1, "raw_count_hold");

        // Same RAW with r5 writing back this cycle
        drive(1'b1, 5'd10, 5'd5, 5'd0, 1'b1, 1'b1, 5'd5);
`ifdef SB_BYPASS_EN
        expect_at(0, K_STALL, 32'd0, "bypass_stall");
        expect_at(1, K_BUSY,  32'h0000_0400, "bypass_busy");
`else
        expect_at(0, K_STALL, 32'd1, "bypass_stall");
        expect_at(1, K_BUSY,  32'h0000_0000, "bypass_busy");
`endif
        expect_at(1, K_WREN,  32'h0000_0020, "wb_r5_wren");

        // Retry: without bypass the dependent issue goes now, with bypass r10 is a WAW
        drive(1'b1, 5'd10, 5'd5, 5'd0, 1'b1, 1'b0, 5'd0);
`ifdef SB_BYPASS_EN
        expect_at(0, K_STALL, 32'd1, "retry_stall");
`else
        expect_at(0, K_STALL, 32'd0, "retry_stall");
`endif
        expect_at(1, K_BUSY,  32'h0000_0400, "retry_busy");
        expect_at(1, K_COUNT, 32'd1, "retry_count");
        expect_at(1, K_WREN,  32'h0, "wren_pulse_end");

        // r7 busy, then written back
        drive(1'b1, 5'd7, 5'd1, 5'd2, 1'b1, 1'b0, 5'd0);
        expect_at(0, K_STALL, 32'd0, "issue_r7_stall");
        expect_at(1, K_BUSY,  32'h0000_0480, "issue_r7_busy");
        expect_at(1, K_COUNT, 32'd2, "issue_r7_count");
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 5'd7);
        expect_at(1, K_WREN,  32'h0000_0080, "wb_r7_wren");
        expect_at(1, K_BUSY,  32'h0000_0400, "wb_r7_busy");
        expect_at(1, K_COUNT, 32'd1, "wb_r7_count");
        expect_at(1, K_ERR,   32'd0, "wb_r7_err");
        idle();
        expect_at(1, K_WREN,  32'h0, "wb_r7_wren_end");

        // r9 busy, then issue rd=9 alongside wb r9
        drive(1'b1, 5'd9, 5'd0, 5'd0, 1'b1, 1'b0, 5'd0);
        expect_at(0, K_STALL, 32'd0, "issue_r9_stall");
        expect_at(1, K_BUSY,  32'h0000_0600, "issue_r9_busy");
        expect_at(1, K_COUNT, 32'd2, "issue_r9_count");
        drive(1'b1, 5'd9, 5'd0, 5'd0, 1'b1, 1'b1, 5'd9);
`ifdef SB_BYPASS_EN
        expect_at(0, K_STALL, 32'd0, "setclr_stall");
        expect_at(1, K_BUSY,  32'h0000_0600, "setclr_busy");
        expect_at(1, K_COUNT, 32'd2, "setclr_count");
`else
        expect_at(0, K_STALL, 32'd1, "setclr_stall");
        expect_at(1, K_BUSY,  32'h0000_0400, "setclr_busy");
        expect_at(1, K_COUNT, 32'd1, "setclr_count");
`endif
        expect_at(1, K_WREN,  32'h0000_0200, "setclr_wren");
        expect_at(1, K_ERR,   32'd0, "setclr_err");

        // Drain r10 (and r9 when still busy)
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 5'd10);
`ifdef SB_BYPASS_EN
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 5'd9);
`endif
        idle();
        expect_at(0, K_BUSY,  32'h0, "drained_busy");
        expect_at(0, K_COUNT, 32'd0, "drained_count");

        // Register 0 is neither tracked nor written
        drive(1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 1'b1, 5'd0);
        expect_at(0, K_STALL, 32'd0, "zero_stall");
        expect_at(1, K_BUSY,  32'h0, "zero_busy");
        expect_at(1, K_WREN,  32'h0, "zero_wren");
        expect_at(1, K_ERR,   32'd0, "zero_err");

        // Writeback to idle r3 is an error, sticky
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 5'd3);
        expect_at(1, K_ERR,   32'd1, "err_set");
        expect_at(1, K_WREN,  32'h0000_0008, "err_wren");
        expect_at(1, K_BUSY,  32'h0, "err_busy");
        idle();
        idle();
        expect_at(0, K_ERR,   32'd1, "err_sticky");

        // Fill r1..r31
        for (int i = 1; i < 32; i++) begin
            drive(1'b1, reg_addr_t'(i), 5'd0, 5'd0, 1'b1, 1'b0, 5'd0);
            expect_at(0, K_STALL, 32'd0, "fill_stall");
        end
        idle();
        expect_at(0, K_BUSY,  32'hFFFF_FFFE, "fill_busy");
        expect_at(0, K_COUNT, 32'd31, "fill_count");

        // Async reset mid-cycle, checked before any clock edge
        @(posedge clock);
        #3;
        reset = 1'b1;
        #1;
        expect_at(-1, K_BUSY,  32'h0, "async_rst_busy");
        expect_at(-1, K_COUNT, 32'd0, "async_rst_count");
        expect_at(-1, K_ERR,   32'd0, "async_rst_err");
        expect_at(-1, K_WREN,  32'h0, "async_rst_wren");
        -> chk_ev;

        @(posedge clock);
        #1;
        reset = 1'b0;
        drive(1'b1, 5'd5, 5'd1, 5'd2, 1'b1, 1'b0, 5'd0);
        expect_at(0, K_STALL, 32'd0, "post_rst_stall");
        expect_at(1, K_BUSY,  32'h0000_0020, "post_rst_busy");
        expect_at(1, K_COUNT, 32'd1, "post_rst_count");
        idle();
        repeat (3) @(posedge clock);
        #6;
        if (q.size() != 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL drain: %0d expectations never sampled", q.size());
        end
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
